stereo_lr_scheduler: RTL and testbench



---
 rtl/audio_pkg.sv | 12 +
 rtl/attenuator.sv | 18 +
 rtl/stereo_lr_scheduler.sv | 108 ++++++++++
 tb/tb_stereo_lr_scheduler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and defaults for the stereo audio scheduling path.
package audio_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_SHIFT_WIDTH = 5;

    typedef enum logic {
        S_LEFT  = 1'b0,
        S_RIGHT = 1'b1
    } lr_state_t;

endpackage

// File: rtl/attenuator.sv
// Combinational volume stage: signed arithmetic right shift followed by mute.
module attenuator #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic [DATA_WIDTH-1:0]  sample_i,
    input  logic [SHIFT_WIDTH-1:0] shift_i,
    input  logic                   mute_i,
    output logic [DATA_WIDTH-1:0]  sample_o
);

    logic signed [DATA_WIDTH-1:0] shifted;

    // Oversized shifts degrade to pure sign fill, which is the intended floor.
    assign shifted  = $signed(sample_i) >>> shift_i;
    assign sample_o = mute_i ? '0 : shifted;

endmodule

// File: rtl/stereo_lr_scheduler.sv
// Interleaves left/right FWFT FIFO streams into one output FIFO as L,R,L,R with
// per-pair attenuation/mute latched at the left write, and counts finished pairs.
module stereo_lr_scheduler
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SHIFT_WIDTH = DEFAULT_SHIFT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  left_dout,
    input  logic                   left_empty,
    output logic                   left_rd_en,
    input  logic [DATA_WIDTH-1:0]  right_dout,
    input  logic                   right_empty,
    output logic                   right_rd_en,
    output logic [DATA_WIDTH-1:0]  out_din,
    input  logic                   out_full,
    output logic                   out_wr_en,
    input  logic [SHIFT_WIDTH-1:0] volume_shift,
    input  logic                   mute,
    output logic [31:0]            pair_count,
    output logic                   expect_right
);

    lr_state_t               state_q, state_d;
    logic [SHIFT_WIDTH-1:0]  vol_q, vol_d;
    logic                    mute_q, mute_d;
    logic [31:0]             pair_count_q, pair_count_d;

    logic [DATA_WIDTH-1:0]   att_sample;
    logic [SHIFT_WIDTH-1:0]  att_shift;
    logic                    att_mute;
    logic [DATA_WIDTH-1:0]   att_result;

    // Single attenuator; its operands follow whichever channel the state selects.
    attenuator #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_attenuator (
        .sample_i (att_sample),
        .shift_i  (att_shift),
        .mute_i   (att_mute),
        .sample_o (att_result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_LEFT;
            vol_q        <= '0;
            mute_q       <= 1'b0;
            pair_count_q <= '0;
        end else begin
            state_q      <= state_d;
            vol_q        <= vol_d;
            mute_q       <= mute_d;
            pair_count_q <= pair_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vol_d        = vol_q;
        mute_d       = mute_q;
        pair_count_d = pair_count_q;
        left_rd_en   = 1'b0;
        right_rd_en  = 1'b0;
        out_wr_en    = 1'b0;
        out_din      = '0;
        expect_right = 1'b0;
        att_sample   = left_dout;
        att_shift    = volume_shift;
        att_mute     = mute;

        case (state_q)
            S_LEFT: begin
                if (!left_empty && !out_full) begin
                    left_rd_en = 1'b1;
                    out_wr_en  = 1'b1;
                    out_din    = att_result;
                    vol_d      = volume_shift;
                    mute_d     = mute;
                    state_d    = S_RIGHT;
                end
            end
            S_RIGHT: begin
                expect_right = 1'b1;
                // Right sample uses the settings captured with its left partner.
                att_sample   = right_dout;
                att_shift    = vol_q;
                att_mute     = mute_q;
                if (!right_empty && !out_full) begin
                    right_rd_en  = 1'b1;
                    out_wr_en    = 1'b1;
                    out_din      = att_result;
                    pair_count_d = pair_count_q + 32'd1;
                    state_d      = S_LEFT;
                end
            end
            default: begin
                state_d = S_LEFT;
            end
        endcase
    end

    assign pair_count = pair_count_q;

endmodule

// File: tb/tb_stereo_lr_scheduler.sv
// Directed bench: queue-modelled FWFT FIFOs around the scheduler, checked per cycle.
module tb_stereo_lr_scheduler;

    logic        clock;
    logic        reset;
    logic [31:0] left_dout, right_dout, out_din;
    logic        left_empty, right_empty, left_rd_en, right_rd_en;
    logic        out_full, out_wr_en, mute, expect_right;
    logic [4:0]  volume_shift;
    logic [31:0] pair_count;

    logic [31:0] lq[$];
    logic [31:0] rq[$];
    int          tests;
    int          fails;
    logic        cap_l, cap_r, cap_w;
    logic [31:0] cap_d;
    logic        any_strobe;

    stereo_lr_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .left_dout    (left_dout),
        .left_empty   (left_empty),
        .left_rd_en   (left_rd_en),
        .right_dout   (right_dout),
        .right_empty  (right_empty),
        .right_rd_en  (right_rd_en),
        .out_din      (out_din),
        .out_full     (out_full),
        .out_wr_en    (out_wr_en),
        .volume_shift (volume_shift),
        .mute         (mute),
        .pair_count   (pair_count),
        .expect_right (expect_right)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic refresh();
        left_empty  = (lq.size() == 0);
        left_dout   = left_empty ? 32'd0 : lq[0];
        right_empty = (rq.size() == 0);
        right_dout  = right_empty ? 32'd0 : rq[0];
    endtask

    // One clock cycle: sample strobes before the edge, then pop what was read.
    task automatic tick();
        refresh();
        #1;
        cap_l = left_rd_en;
        cap_r = right_rd_en;
        cap_w = out_wr_en;
        cap_d = out_din;
        @(posedge clock);
        #1;
        if (cap_l && lq.size() > 0) void'(lq.pop_front());
        if (cap_r && rq.size() > 0) void'(rq.pop_front());
        refresh();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic write_step(input string tag, input logic is_left, input logic [31:0] exp);
        tick();
        chk({tag, "_wr"}, {31'd0, cap_w}, 32'd1);
        chk({tag, "_rd"}, {30'd0, cap_l, cap_r}, is_left ? 32'd2 : 32'd1);
        chk({tag, "_din"}, cap_d, exp);
        $display("[TB] %s: wr=%0b l=%0b r=%0b din=%0d", tag, cap_w, cap_l, cap_r, $signed(cap_d));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        out_full = 1'b0;
        mute = 1'b0;
        volume_shift = 5'd0;
        refresh();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_pair_count", pair_count, 32'd0);
        chk("rst_expect_right", {31'd0, expect_right}, 32'd0);
        chk("rst_strobes", {29'd0, left_rd_en, right_rd_en, out_wr_en}, 32'd0);
        chk("rst_out_din", out_din, 32'd0);
        reset = 1'b0;

        // 1: back-to-back pairs at full rate
        lq.push_back(32'd100); lq.push_back(32'd200);
        rq.push_back(-32'sd100); rq.push_back(-32'sd200);
        write_step("t1_l0", 1'b1, 32'd100);
        write_step("t1_r0", 1'b0, -32'sd100);
        write_step("t1_l1", 1'b1, 32'd200);
        write_step("t1_r1", 1'b0, -32'sd200);
        chk("t1_pairs", pair_count, 32'd2);

        // 2: attenuation and full sign fill
        volume_shift = 5'd3;
        lq.push_back(32'd1024); rq.push_back(-32'sd1024);
        write_step("t2_l", 1'b1, 32'd128);
        write_step("t2_r", 1'b0, -32'sd128);
        volume_shift = 5'd31;
        lq.push_back(-32'sd5); rq.push_back(32'd7);
        write_step("t2_l31", 1'b1, 32'hFFFF_FFFF);
        write_step("t2_r31", 1'b0, 32'd0);
        chk("t2_pairs", pair_count, 32'd4);

        // 3: volume latched at the left write
        volume_shift = 5'd2;
        lq.push_back(32'd64); lq.push_back(32'd64);
        rq.push_back(32'd64); rq.push_back(32'd64);
        write_step("t3_l0", 1'b1, 32'd16);
        volume_shift = 5'd5;
        write_step("t3_r0", 1'b0, 32'd16);
        write_step("t3_l1", 1'b1, 32'd2);
        write_step("t3_r1", 1'b0, 32'd2);
        chk("t3_pairs", pair_count, 32'd6);

        // 4: right starvation stalls without touching the left FIFO
        volume_shift = 5'd0;
        lq.push_back(32'd10); lq.push_back(32'd20); lq.push_back(32'd30);
        write_step("t4_l0", 1'b1, 32'd10);
        any_strobe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cap_l || cap_r || cap_w) any_strobe = 1'b1;
        end
        chk("t4_stall_strobes", {31'd0, any_strobe}, 32'd0);
        chk("t4_expect_right", {31'd0, expect_right}, 32'd1);
        chk("t4_left_left", lq.size(), 32'd2);
        rq.push_back(32'd11);
        write_step("t4_r0", 1'b0, 32'd11);
        chk("t4_pairs", pair_count, 32'd7);
        rq.push_back(32'd21); rq.push_back(32'd31);
        write_step("t4_l1", 1'b1, 32'd20);
        write_step("t4_r1", 1'b0, 32'd21);
        write_step("t4_l2", 1'b1, 32'd30);
        write_step("t4_r2", 1'b0, 32'd31);
        chk("t4_pairs_end", pair_count, 32'd9);

        // 5: output back-pressure mid-pair
        lq.push_back(32'd1); lq.push_back(32'd2);
        rq.push_back(32'd3); rq.push_back(32'd4);
        write_step("t5_l0", 1'b1, 32'd1);
        out_full = 1'b1;
        any_strobe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cap_l || cap_r || cap_w) any_strobe = 1'b1;
        end
        chk("t5_full_strobes", {31'd0, any_strobe}, 32'd0);
        out_full = 1'b0;
        write_step("t5_r0", 1'b0, 32'd3);
        write_step("t5_l1", 1'b1, 32'd2);
        write_step("t5_r1", 1'b0, 32'd4);
        chk("t5_pairs", pair_count, 32'd11);

        // 6: asynchronous reset mid-pair, then a muted pair
        lq.push_back(32'd5);
        write_step("t6_l_pre", 1'b1, 32'd5);
        chk("t6_in_right", {31'd0, expect_right}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_expect", {31'd0, expect_right}, 32'd0);
        chk("t6_rst_pairs", pair_count, 32'd0);
        tick();
        reset = 1'b0;
        rq.push_back(32'd6); lq.push_back(32'd7);
        write_step("t6_l", 1'b1, 32'd7);
        write_step("t6_r", 1'b0, 32'd6);
        chk("t6_pairs", pair_count, 32'd1);
        mute = 1'b1;
        lq.push_back(32'd9); rq.push_back(32'd9);
        write_step("t6_mute_l", 1'b1, 32'd0);
        mute = 1'b0;
        write_step("t6_mute_r", 1'b0, 32'd0);
        chk("t6_pairs_end", pair_count, 32'd2);
        chk("t6_fifos_drained", lq.size() + rq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
